// File: rtl/enc_pkg.sv
//------------------------------------------------------------------------------
// enc_pkg : shared widths and depth for the encoder code FIFO
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package enc_pkg;
  localparam int ENC_W          = 2;
  localparam int ENC_FIFO_DEPTH = 4;

  function automatic int enc_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

`default_nettype wire

// File: rtl/enc_event_detect.sv
//------------------------------------------------------------------------------
// enc_event_detect : flags a new valid encoder code (rising v or y change)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module enc_event_detect
  import enc_pkg::*;
#(
  parameter int W = ENC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v,
  input  logic [W-1:0] y,
  output logic         o_event
);

  logic         r_prev_v;
  logic [W-1:0] r_prev_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_v <= 1'b0;
      r_prev_y <= '0;
    end else begin
      r_prev_v <= v;
      r_prev_y <= y;
    end
  end

  assign o_event = v & (~r_prev_v | (y != r_prev_y));

endmodule

`default_nettype wire

// File: rtl/enc_code_fifo.sv
//------------------------------------------------------------------------------
// enc_code_fifo : FWFT queue of encoder codes with drop-on-full overflow flag
// Config macro: ENC_FIFO_OVF_STICKY_EN (sticky overflow; default is 1-cycle pulse)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module enc_code_fifo
  import enc_pkg::*;
#(
  parameter int DEPTH = ENC_FIFO_DEPTH,
  parameter int W     = ENC_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         v,
  input  logic [W-1:0]                 y,
  input  logic                         rd_en,
  output logic [W-1:0]                 dout,
  output logic                         empty,
  output logic                         full,
  output logic [enc_cnt_w(DEPTH)-1:0]  count,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = enc_cnt_w(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_event;
  logic w_push;
  logic w_pop;
  logic w_drop;

  enc_event_detect #(.W(W)) u_event_detect (
    .clk     (clk),
    .rst     (rst),
    .v       (v),
    .y       (y),
    .o_event (w_event)
  );

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

  // A pop on a full queue frees the slot the simultaneous push needs.
  assign w_pop  = rd_en & ~empty;
  assign w_push = w_event & (~full | w_pop);
  assign w_drop = w_event & ~w_push;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
`ifdef ENC_FIFO_OVF_STICKY_EN
      if (w_drop) r_overflow <= 1'b1;
`else
      r_overflow <= w_drop;
`endif
    end
  end

  assign dout     = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

`default_nettype wire
